// File: rtl/tlb_refill_arbiter_if.sv
// Bundle of the ITLB/DTLB miss-refill channels and the page-table-walker
// request/response channel shared by tlb_refill_arbiter.
//
//   itlb_* / dtlb_*  miss_req + miss_vpn in, refill_valid/ppn/fault out
//   ptw_req_*        valid/ready walk request carrying the granted VPN
//   ptw_resp_*       one-cycle walk result (ppn + fault)
//
// Modports:
//   master : the arbiter side (drives refills and walk requests)
//   slave  : the environment side (TLBs and the walker)
interface tlb_refill_arbiter_if #(
  parameter int VPN_W = 22,
  parameter int PPN_W = 22
);
  logic             itlb_miss_req;
  logic [VPN_W-1:0] itlb_miss_vpn;
  logic             itlb_refill_valid;
  logic [PPN_W-1:0] itlb_refill_ppn;
  logic             itlb_refill_fault;

  logic             dtlb_miss_req;
  logic [VPN_W-1:0] dtlb_miss_vpn;
  logic             dtlb_refill_valid;
  logic [PPN_W-1:0] dtlb_refill_ppn;
  logic             dtlb_refill_fault;

  logic             ptw_req_valid;
  logic             ptw_req_ready;
  logic [VPN_W-1:0] ptw_req_vpn;
  logic             ptw_resp_valid;
  logic [PPN_W-1:0] ptw_resp_ppn;
  logic             ptw_resp_fault;

  modport master (
    input  itlb_miss_req, itlb_miss_vpn, dtlb_miss_req, dtlb_miss_vpn,
           ptw_req_ready, ptw_resp_valid, ptw_resp_ppn, ptw_resp_fault,
    output itlb_refill_valid, itlb_refill_ppn, itlb_refill_fault,
           dtlb_refill_valid, dtlb_refill_ppn, dtlb_refill_fault,
           ptw_req_valid, ptw_req_vpn
  );

  modport slave (
    output itlb_miss_req, itlb_miss_vpn, dtlb_miss_req, dtlb_miss_vpn,
           ptw_req_ready, ptw_resp_valid, ptw_resp_ppn, ptw_resp_fault,
    input  itlb_refill_valid, itlb_refill_ppn, itlb_refill_fault,
           dtlb_refill_valid, dtlb_refill_ppn, dtlb_refill_fault,
           ptw_req_valid, ptw_req_vpn
  );
endinterface

// File: rtl/tlb_refill_arbiter.sv
// Shares one page-table-walker port between the ITLB and DTLB miss paths.
// One miss is serviced at a time; ties are broken round-robin. The granted
// VPN is issued over a valid/ready handshake, the walk result (or a forced
// fault after WALK_TIMEOUT silent cycles) is returned to the granted TLB as
// a one-cycle refill pulse.
//
// Ports:
//   clock  : rising-edge clock
//   reset  : synchronous, active-low
//   bus    : tlb_refill_arbiter_if.master (miss/refill and PTW channels)
//   busy   : high whenever a walk is in progress (state != IDLE)
module tlb_refill_arbiter #(
  parameter int VPN_W        = 22,
  parameter int PPN_W        = 22,
  parameter int WALK_TIMEOUT = 64
) (
  input  logic                 clock,
  input  logic                 reset,
  tlb_refill_arbiter_if.master bus,
  output logic                 busy
);
  localparam int CNT_W = $clog2(WALK_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WALK_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state_q, state_d;
  logic             grant_d_q, grant_d_d;  // 1: DTLB holds / last held the grant
  logic [VPN_W-1:0] vpn_q, vpn_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PPN_W-1:0] ppn_q, ppn_d;
  logic             fault_q, fault_d;
  logic             pulse_i, pulse_d;

  // NOTE: every register, data included, is reset: ptw_req_vpn is a visible
  // output that must read 0 after reset, and the captured result must never
  // leak from a walk abandoned by reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= IDLE;
      grant_d_q <= 1'b1;  // so the first tie goes to the ITLB
      vpn_q     <= '0;
      cnt_q     <= '0;
      ppn_q     <= '0;
      fault_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all state updates see the values
      // from before the edge, independent of statement order.
      state_q   <= state_d;
      grant_d_q <= grant_d_d;
      vpn_q     <= vpn_d;
      cnt_q     <= cnt_d;
      ppn_q     <= ppn_d;
      fault_q   <= fault_d;
    end
  end

  always_comb begin
    // NOTE: hold-value defaults first, so no path through the case leaves a
    // signal unassigned and infers a latch.
    state_d   = state_q;
    grant_d_d = grant_d_q;
    vpn_d     = vpn_q;
    cnt_d     = cnt_q;
    ppn_d     = ppn_q;
    fault_d   = fault_q;

    case (state_q)
      IDLE: begin
        // Responses seen here are stale leftovers of a timed-out walk.
        if (bus.itlb_miss_req || bus.dtlb_miss_req) begin
          if (bus.itlb_miss_req && bus.dtlb_miss_req) begin
            grant_d_d = !grant_d_q;
          end else begin
            grant_d_d = bus.dtlb_miss_req;
          end
          vpn_d   = grant_d_d ? bus.dtlb_miss_vpn : bus.itlb_miss_vpn;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.ptw_req_ready) begin
          cnt_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // A response takes priority over a timeout in the same cycle.
        if (bus.ptw_resp_valid) begin
          ppn_d   = bus.ptw_resp_fault ? '0 : bus.ptw_resp_ppn;
          fault_d = bus.ptw_resp_fault;
          state_d = RESP;
        end else if (cnt_q == CNT_LAST) begin
          ppn_d   = '0;
          fault_d = 1'b1;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign pulse_i = (state_q == RESP) && !grant_d_q;
  assign pulse_d = (state_q == RESP) &&  grant_d_q;

  assign bus.itlb_refill_valid = pulse_i;
  assign bus.itlb_refill_ppn   = pulse_i ? ppn_q : '0;
  assign bus.itlb_refill_fault = pulse_i && fault_q;
  assign bus.dtlb_refill_valid = pulse_d;
  assign bus.dtlb_refill_ppn   = pulse_d ? ppn_q : '0;
  assign bus.dtlb_refill_fault = pulse_d && fault_q;

  assign bus.ptw_req_valid = (state_q == ISSUE);
  assign bus.ptw_req_vpn   = vpn_q;
  assign busy              = (state_q != IDLE);
endmodule

// File: tb/tb_tlb_refill_arbiter.sv
module tb_tlb_refill_arbiter;
  localparam int VPN_W = 22;
  localparam int PPN_W = 22;
  localparam int WALK_TIMEOUT = 64;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic busy;
  int   checks = 0;
  int   failures = 0;

  tlb_refill_arbiter_if #(.VPN_W(VPN_W), .PPN_W(PPN_W)) bus ();

  tlb_refill_arbiter #(.VPN_W(VPN_W), .PPN_W(PPN_W), .WALK_TIMEOUT(WALK_TIMEOUT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master),
    .busy  (busy)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  // One row: inputs applied at a falling edge, outputs expected one cycle later.
  typedef struct {
    logic        ireq;
    logic [21:0] ivpn;
    logic        dreq;
    logic [21:0] dvpn;
    logic        ready;
    logic        rvalid;
    logic [21:0] rppn;
    logic        rfault;
    logic        e_busy;
    logic        e_pv;
    logic [21:0] e_pvpn;
    logic [23:0] e_i;  // {valid, fault, ppn}
    logic [23:0] e_d;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  function automatic logic [23:0] i_pack();
    return {bus.itlb_refill_valid, bus.itlb_refill_fault, bus.itlb_refill_ppn};
  endfunction

  function automatic logic [23:0] d_pack();
    return {bus.dtlb_refill_valid, bus.dtlb_refill_fault, bus.dtlb_refill_ppn};
  endfunction

  task automatic clear_inputs();
    bus.itlb_miss_req  = 1'b0;
    bus.itlb_miss_vpn  = '0;
    bus.dtlb_miss_req  = 1'b0;
    bus.dtlb_miss_vpn  = '0;
    bus.ptw_req_ready  = 1'b0;
    bus.ptw_resp_valid = 1'b0;
    bus.ptw_resp_ppn   = '0;
    bus.ptw_resp_fault = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, " itlb"}, 32'(i_pack()), 32'd0);
    check({tag, " dtlb"}, 32'(d_pack()), 32'd0);
    check({tag, " busy/valid"}, 32'({busy, bus.ptw_req_valid}), 32'd0);
  endtask

  task automatic check_reset(input string tag);
    check_quiet(tag);
    check({tag, " req_vpn"}, 32'(bus.ptw_req_vpn), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    clear_inputs();
    tick();
    tick();
    reset = 1'b1;
  endtask

  // Waits for the grant, accepts at once, answers one cycle later and checks
  // the refill pulse on the expected side; ends in the IDLE cycle.
  task automatic run_walk(input string tag, input logic side_d, input logic [21:0] vpn,
                          input logic [21:0] ppn, input logic fault, input logic [23:0] exp_pack);
    int n = 0;
    while (!bus.ptw_req_valid && n < 20) begin
      tick();
      n++;
    end
    check({tag, " grant"}, 32'(bus.ptw_req_valid), 32'd1);
    if (!bus.ptw_req_valid) return;
    check({tag, " vpn"}, 32'(bus.ptw_req_vpn), 32'(vpn));
    bus.ptw_req_ready = 1'b1;
    tick();
    bus.ptw_req_ready  = 1'b0;
    bus.ptw_resp_valid = 1'b1;
    bus.ptw_resp_ppn   = ppn;
    bus.ptw_resp_fault = fault;
    tick();
    bus.ptw_resp_valid = 1'b0;
    bus.ptw_resp_ppn   = '0;
    bus.ptw_resp_fault = 1'b0;
    check({tag, " itlb refill"}, 32'(i_pack()), side_d ? 32'd0 : 32'(exp_pack));
    check({tag, " dtlb refill"}, 32'(d_pack()), side_d ? 32'(exp_pack) : 32'd0);
    if (side_d) bus.dtlb_miss_req = 1'b0;
    else        bus.itlb_miss_req = 1'b0;
    tick();
    check({tag, " pulse one cycle"}, 32'({bus.itlb_refill_valid, bus.dtlb_refill_valid}), 32'd0);
  endtask

  // Accepts the walk, then drives a response at WAIT-cycle index resp_at
  // (negative: never) and checks how many cycles until the pulse.
  task automatic long_walk(input string tag, input logic side_d, input int resp_at,
                           input logic [21:0] ppn, input logic [23:0] exp_pack, input int exp_n);
    int n = 0;
    while (!bus.ptw_req_valid && n < 20) begin
      tick();
      n++;
    end
    bus.ptw_req_ready = 1'b1;
    tick();
    bus.ptw_req_ready = 1'b0;
    n = 0;
    while (!(bus.itlb_refill_valid || bus.dtlb_refill_valid) && n < 200) begin
      bus.ptw_resp_valid = (n == resp_at);
      bus.ptw_resp_ppn   = ppn;
      tick();
      n++;
    end
    bus.ptw_resp_valid = 1'b0;
    check({tag, " cycles to pulse"}, 32'(n), 32'(exp_n));
    check({tag, " refill"}, side_d ? 32'(d_pack()) : 32'(i_pack()), 32'(exp_pack));
    if (side_d) bus.dtlb_miss_req = 1'b0;
    else        bus.itlb_miss_req = 1'b0;
  endtask

  // Randomized traffic against a transaction-level model: round-robin choice
  // over the requesters pending at grant time, and the walk outcome the
  // responder chose.
  bit          last_d, prev_pv, exp_active, exp_side, waiting, no_resp, r_fault;
  bit          drop_i, drop_d, abort_rnd, want_d;
  int          resp_wait, since_grant;
  logic [21:0] r_ppn;
  logic [23:0] exp_pack;

  task automatic rnd_step(input bit allow_new);
    drop_i = 1'b0;
    drop_d = 1'b0;
    if (bus.itlb_refill_valid || bus.dtlb_refill_valid) begin
      check("rnd pulse expected", 32'(exp_active), 32'd1);
      check("rnd pulse side", 32'({bus.itlb_refill_valid, bus.dtlb_refill_valid}),
            exp_side ? 32'd1 : 32'd2);
      check("rnd refill data", exp_side ? 32'(d_pack()) : 32'(i_pack()), 32'(exp_pack));
      exp_active = 1'b0;
      if (bus.itlb_refill_valid) begin bus.itlb_miss_req = 1'b0; drop_i = 1'b1; end
      if (bus.dtlb_refill_valid) begin bus.dtlb_miss_req = 1'b0; drop_d = 1'b1; end
    end
    if (bus.ptw_req_valid && !prev_pv) begin
      check("rnd grant has requester", 32'(bus.itlb_miss_req || bus.dtlb_miss_req), 32'd1);
      check("rnd grant while idle", 32'(exp_active), 32'd0);
      want_d = (bus.itlb_miss_req && bus.dtlb_miss_req) ? !last_d : bus.dtlb_miss_req;
      last_d = want_d;
      check("rnd grant vpn", 32'(bus.ptw_req_vpn),
            want_d ? 32'(bus.dtlb_miss_vpn) : 32'(bus.itlb_miss_vpn));
      exp_active  = 1'b1;
      exp_side    = want_d;
      since_grant = 0;
    end
    if (exp_active) begin
      since_grant++;
      if (since_grant > 200) begin
        check("rnd walk watchdog", 32'(since_grant), 32'd0);
        abort_rnd = 1'b1;
      end
    end
    // Responder: garbage data whenever not answering.
    bus.ptw_resp_valid = 1'b0;
    bus.ptw_resp_ppn   = 22'($urandom);
    bus.ptw_resp_fault = 1'($urandom_range(0, 1));
    if (waiting) begin
      if (resp_wait == 0) begin
        waiting = 1'b0;
        if (!no_resp) begin
          bus.ptw_resp_valid = 1'b1;
          bus.ptw_resp_ppn   = r_ppn;
          bus.ptw_resp_fault = r_fault;
        end
      end else begin
        resp_wait--;
      end
    end else if (!busy && $urandom_range(0, 7) == 0) begin
      bus.ptw_resp_valid = 1'b1;  // stale response while idle
    end
    bus.ptw_req_ready = ($urandom_range(0, 3) != 0);
    if (bus.ptw_req_valid && bus.ptw_req_ready) begin
      waiting   = 1'b1;
      resp_wait = $urandom_range(0, 4);
      no_resp   = ($urandom_range(0, 15) == 0);
      r_fault   = ($urandom_range(0, 3) == 0);
      r_ppn     = 22'($urandom);
      exp_pack  = (no_resp || r_fault) ? {2'b11, 22'h0} : {2'b10, r_ppn};
    end
    if (allow_new && !bus.itlb_miss_req && !drop_i && $urandom_range(0, 3) == 0) begin
      bus.itlb_miss_req = 1'b1;
      bus.itlb_miss_vpn = 22'($urandom);
    end
    if (allow_new && !bus.dtlb_miss_req && !drop_d && $urandom_range(0, 3) == 0) begin
      bus.dtlb_miss_req = 1'b1;
      bus.dtlb_miss_vpn = 22'($urandom);
    end
    prev_pv = bus.ptw_req_valid;
    tick();
  endtask

  initial begin
    //                ireq ivpn      dreq dvpn ready rv rppn      rf  busy pv pvpn      itlb                      dtlb
    vecs[0] = '{1'b1, 22'h00ABC, 1'b0, 22'h0, 1'b1, 1'b0, 22'h0,     1'b0, 1'b1, 1'b1, 22'h00ABC, 24'h0,                     24'h0};
    vecs[1] = '{1'b1, 22'h00ABC, 1'b0, 22'h0, 1'b1, 1'b0, 22'h0,     1'b0, 1'b1, 1'b0, 22'h00ABC, 24'h0,                     24'h0};
    vecs[2] = '{1'b1, 22'h00ABC, 1'b0, 22'h0, 1'b0, 1'b0, 22'h0,     1'b0, 1'b1, 1'b0, 22'h00ABC, 24'h0,                     24'h0};
    vecs[3] = '{1'b1, 22'h00ABC, 1'b0, 22'h0, 1'b0, 1'b1, 22'h12345, 1'b0, 1'b1, 1'b0, 22'h00ABC, {1'b1, 1'b0, 22'h12345}, 24'h0};
    vecs[4] = '{1'b0, 22'h00ABC, 1'b0, 22'h0, 1'b0, 1'b0, 22'h0,     1'b0, 1'b0, 1'b0, 22'h00ABC, 24'h0,                     24'h0};

    do_reset();
    check_reset("reset state");

    // Single ITLB miss, table driven.
    for (int i = 0; i < 5; i++) begin
      bus.itlb_miss_req  = vecs[i].ireq;
      bus.itlb_miss_vpn  = vecs[i].ivpn;
      bus.dtlb_miss_req  = vecs[i].dreq;
      bus.dtlb_miss_vpn  = vecs[i].dvpn;
      bus.ptw_req_ready  = vecs[i].ready;
      bus.ptw_resp_valid = vecs[i].rvalid;
      bus.ptw_resp_ppn   = vecs[i].rppn;
      bus.ptw_resp_fault = vecs[i].rfault;
      tick();
      check($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].e_busy));
      check($sformatf("vec%0d req_valid", i), 32'(bus.ptw_req_valid), 32'(vecs[i].e_pv));
      check($sformatf("vec%0d req_vpn", i), 32'(bus.ptw_req_vpn), 32'(vecs[i].e_pvpn));
      check($sformatf("vec%0d itlb", i), 32'(i_pack()), 32'(vecs[i].e_i));
      check($sformatf("vec%0d dtlb", i), 32'(d_pack()), 32'(vecs[i].e_d));
    end
    clear_inputs();

    // Ties: ITLB first after reset, then strict alternation.
    do_reset();
    bus.itlb_miss_req = 1'b1; bus.itlb_miss_vpn = 22'h1;
    bus.dtlb_miss_req = 1'b1; bus.dtlb_miss_vpn = 22'h2;
    run_walk("tie1 I", 1'b0, 22'h1, 22'h101, 1'b0, {2'b10, 22'h101});
    run_walk("tie1 D", 1'b1, 22'h2, 22'h202, 1'b0, {2'b10, 22'h202});
    bus.itlb_miss_req = 1'b1; bus.itlb_miss_vpn = 22'h3;
    bus.dtlb_miss_req = 1'b1; bus.dtlb_miss_vpn = 22'h4;
    run_walk("tie2 I", 1'b0, 22'h3, 22'h303, 1'b0, {2'b10, 22'h303});
    bus.itlb_miss_req = 1'b1; bus.itlb_miss_vpn = 22'h5;
    run_walk("tie3 D", 1'b1, 22'h4, 22'h404, 1'b0, {2'b10, 22'h404});
    bus.dtlb_miss_req = 1'b1; bus.dtlb_miss_vpn = 22'h6;
    run_walk("tie4 I", 1'b0, 22'h5, 22'h505, 1'b0, {2'b10, 22'h505});
    run_walk("tie5 D", 1'b1, 22'h6, 22'h606, 1'b0, {2'b10, 22'h606});

    // Walker not ready for 10 cycles: request held stable, no timeout.
    bus.itlb_miss_req = 1'b1; bus.itlb_miss_vpn = 22'h155;
    tick();
    for (int k = 0; k < 10; k++) begin
      check($sformatf("hold%0d valid/busy", k), 32'({bus.ptw_req_valid, busy}), 32'd3);
      check($sformatf("hold%0d vpn", k), 32'(bus.ptw_req_vpn), 32'h155);
      tick();
    end
    run_walk("hold walk", 1'b0, 22'h155, 22'h0BEEF, 1'b0, {2'b10, 22'h0BEEF});

    // Walker fault forces ppn to 0.
    bus.itlb_miss_req = 1'b1; bus.itlb_miss_vpn = 22'h777;
    run_walk("fault", 1'b0, 22'h777, 22'h3FFFFF, 1'b1, {2'b11, 22'h0});

    // Timeout, then late responses are ignored.
    bus.dtlb_miss_req = 1'b1; bus.dtlb_miss_vpn = 22'h0F0F;
    long_walk("timeout", 1'b1, -1, 22'h0, {2'b11, 22'h0}, WALK_TIMEOUT);
    bus.ptw_resp_valid = 1'b1; bus.ptw_resp_ppn = 22'h1111;
    tick();
    check_quiet("late resp 1");
    tick();
    bus.ptw_resp_valid = 1'b0;
    check_quiet("late resp 2");

    // Response on the timeout cycle wins.
    bus.itlb_miss_req = 1'b1; bus.itlb_miss_vpn = 22'h0A0A;
    long_walk("resp vs timeout", 1'b0, WALK_TIMEOUT - 1, 22'h2AAAA, {2'b10, 22'h2AAAA}, WALK_TIMEOUT);
    tick();

    // Reset while waiting for the walker.
    bus.dtlb_miss_req = 1'b1; bus.dtlb_miss_vpn = 22'h2468;
    tick();
    bus.ptw_req_ready = 1'b1;
    tick();
    bus.ptw_req_ready = 1'b0;
    tick();
    tick();
    check("pre-reset busy", 32'(busy), 32'd1);
    reset = 1'b0;
    tick();
    check_reset("reset in WAIT");
    reset = 1'b1;
    bus.dtlb_miss_req  = 1'b0;
    bus.ptw_resp_valid = 1'b1; bus.ptw_resp_ppn = 22'h5555;
    tick();
    bus.ptw_resp_valid = 1'b0;
    check_quiet("post-reset resp 1");
    tick();
    check_quiet("post-reset resp 2");
    bus.itlb_miss_req = 1'b1; bus.itlb_miss_vpn = 22'h999;
    run_walk("post-reset walk", 1'b0, 22'h999, 22'h3ABCD, 1'b0, {2'b10, 22'h3ABCD});

    // Randomized traffic.
    do_reset();
    last_d = 1'b1; prev_pv = 1'b0; exp_active = 1'b0; waiting = 1'b0; abort_rnd = 1'b0;
    for (int cyc = 0; cyc < 3000 && !abort_rnd; cyc++) rnd_step(1'b1);
    for (int cyc = 0; cyc < 500 && !abort_rnd; cyc++) rnd_step(1'b0);
    check("rnd drained", 32'({bus.itlb_miss_req, bus.dtlb_miss_req, exp_active}), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
